seq_pattern_tx: RTL

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_tx_shreg.sv | 56 +++++
 rtl/seq_pattern_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_t      : transmitter FSM states (IDLE, PREAMBLE, DATA)
//   PREAMBLE_PAT : optional sync preamble, sent MSB-first
//   PREAMBLE_LEN : number of preamble bits
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [3:0] PREAMBLE_PAT = 4'b1011;
  localparam int         PREAMBLE_LEN = 4;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register with a remaining-bit down-counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data / load_len (takes priority over shift)
//   shift      : drop the current head bit and move to the next one
//   load_data  : word to transmit, MSB first
//   load_len   : number of bits to transmit (already clamped to DATA_W)
//   next_bit   : bit that will be at the head after this edge
//                (current head if not shifting, following bit if shifting)
//   last       : the current head is the final bit of the word
//   empty      : no bits remain
module seq_tx_shreg #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              next_bit,
  output logic              last,
  output logic              empty
);

  logic [DATA_W-1:0] sr;
  logic [LEN_W-1:0]  cnt;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_len;
    end else if (shift && (cnt != '0)) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  // NOTE: the data register is deliberately left without reset; its
  // contents are meaningless unless cnt (which is reset) says otherwise.
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[DATA_W-2:0], 1'b0};
    end
  end

  assign next_bit = shift ? sr[DATA_W-2] : sr[DATA_W-1];
  assign last     = (cnt == LEN_W'(1));
  assign empty    = (cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word with a bit count and sends
// that many bits MSB-first on a registered serial output, one per cycle.
// Optional feature: define SEQ_TX_PREAMBLE_EN to precede every word with
// the 4-bit preamble 1011 (also for zero-length words).
// Ports:
//   clk       : sole clock, rising edge
//   reset     : synchronous, active-high reset
//   in_valid  : a word is offered
//   in_ready  : word can be accepted this cycle (IDLE and not in reset)
//   in_data   : pattern bits, MSB first
//   in_len    : number of bits to send from the MSB end (clamped to DATA_W)
//   x         : registered serial bit, 0 whenever x_valid is 0
//   x_valid   : x carries a transmitted bit this cycle
//   busy      : a word is in flight (PREAMBLE or DATA)
//   done      : one-cycle pulse in the cycle after the last bit
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  state_t           state, state_d;
  logic             x_d, x_valid_d, done_d;
  logic             accept, load, shift;
  logic             next_bit, last, empty;
  logic [LEN_W-1:0] len_c;

`ifdef SEQ_TX_PREAMBLE_EN
  logic [1:0] pre_idx, pre_idx_d;   // index of the preamble bit now on x
`endif

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign len_c    = (in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : in_len;

  // Kept outside the FSM process so next_bit (which depends on shift)
  // does not feed back into the block that produces shift.
  assign load  = accept;
  assign shift = (state == DATA) && !last && !empty;

  seq_tx_shreg #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .load_len  (len_c),
    .next_bit  (next_bit),
    .last      (last),
    .empty     (empty)
  );

  // x/x_valid/done are computed one cycle ahead and registered, so the
  // serial output comes straight from flops.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
    pre_idx_d = pre_idx;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SEQ_TX_PREAMBLE_EN
          state_d   = PREAMBLE;
          pre_idx_d = 2'd0;
          x_d       = PREAMBLE_PAT[PREAMBLE_LEN-1];
          x_valid_d = 1'b1;
`else
          if (len_c == '0) begin
            // Nothing to send: stay in IDLE and report completion.
            done_d = 1'b1;
          end else begin
            state_d   = DATA;
            x_d       = in_data[DATA_W-1];
            x_valid_d = 1'b1;
          end
`endif
        end
      end
`ifdef SEQ_TX_PREAMBLE_EN
      PREAMBLE: begin
        if (pre_idx == 2'(PREAMBLE_LEN - 1)) begin
          if (empty) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Shift register is not advanced here: its head is the
            // first data bit.
            state_d   = DATA;
            x_d       = next_bit;
            x_valid_d = 1'b1;
          end
        end else begin
          pre_idx_d = pre_idx + 2'd1;
          x_d       = PREAMBLE_PAT[2'(PREAMBLE_LEN - 2) - pre_idx];
          x_valid_d = 1'b1;
        end
      end
`endif
      DATA: begin
        if (last || empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          x_d       = next_bit;
          x_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
      pre_idx <= 2'd0;
`endif
    end else begin
      state   <= state_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      done    <= done_d;
`ifdef SEQ_TX_PREAMBLE_EN
      pre_idx <= pre_idx_d;
`endif
    end
  end

endmodule
